// File: rtl/mem_axi_lite_arb_if.sv
// ---------------------------------------------------------------------------
// mem_axi_lite_arb_if
// AXI4-Lite bus bundle between the core's AXI-Lite master and the
// mem_axi_lite_arb bridge.
//
// Signals (direction seen from the slave):
//   awaddr/awvalid in, awready out      write address channel
//   wdata/wstrb/wvalid in, wready out   write data channel
//   bresp/bvalid out, bready in         write response channel (00 OKAY, 10 SLVERR)
//   araddr/arvalid in, arready out      read address channel
//   rdata/rresp/rvalid out, rready in   read data channel (00 OKAY, 10 SLVERR)
//
// Modports: master (core side), slave (bridge side).
// ---------------------------------------------------------------------------
interface mem_axi_lite_arb_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 64
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/mem_axi_lite_arb.sv
// ---------------------------------------------------------------------------
// mem_axi_lite_arb
// AXI4-Lite slave to single-port memory bridge. AW and W are captured
// independently (any order, or together) into holding registers; a pending
// write (AW and W both held) and a pending read compete for the one memory
// port, with alternation when both are pending. Each memory access is bounded
// by TIMEOUT cycles; an expired access completes with SLVERR.
//
// Ports:
//   clk        clock, all logic on posedge
//   rst        synchronous reset, active-high
//   axi        AXI4-Lite slave bundle (mem_axi_lite_arb_if.slave)
//   addr_mem   memory address (held awaddr during a write access, else held araddr)
//   wdata_mem  held write data
//   wmask_mem  held write strobes
//   rdata_mem  memory read data, valid together with valid_mem
//   valid_mem  memory access complete (only looked at while wen_mem|ren_mem)
//   wen_mem    memory write enable, held until completion
//   ren_mem    memory read enable, held until completion
// ---------------------------------------------------------------------------
module mem_axi_lite_arb #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 64,
    parameter int TIMEOUT    = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    mem_axi_lite_arb_if.slave       axi,
    output logic [ADDR_WIDTH-1:0]   addr_mem,
    output logic [DATA_WIDTH-1:0]   wdata_mem,
    output logic [DATA_WIDTH/8-1:0] wmask_mem,
    input  logic [DATA_WIDTH-1:0]   rdata_mem,
    input  logic                    valid_mem,
    output logic                    wen_mem,
    output logic                    ren_mem
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WACC  = 3'd1;
    localparam logic [2:0] S_RACC  = 3'd2;
    localparam logic [2:0] S_BRESP = 3'd3;
    localparam logic [2:0] S_RRESP = 3'd4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // The counter only has to reach TIMEOUT-1; with TIMEOUT=0 it just wraps.
    localparam int            TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
    localparam bit            HAS_TIMEOUT = (TIMEOUT != 0);

    logic [2:0]              state;
    logic                    aw_full;
    logic                    w_full;
    logic                    ar_full;
    logic [ADDR_WIDTH-1:0]   aw_addr_q;
    logic [ADDR_WIDTH-1:0]   ar_addr_q;
    logic [DATA_WIDTH-1:0]   w_data_q;
    logic [DATA_WIDTH/8-1:0] w_strb_q;
    logic                    last_grant_wr;  // 0: last contended grant went to the read
    logic [TW-1:0]           tcnt;
    logic                    bvalid_q;
    logic [1:0]              bresp_q;
    logic                    rvalid_q;
    logic [1:0]              rresp_q;
    logic [DATA_WIDTH-1:0]   rdata_q;

    logic wr_req;
    logic rd_req;
    logic grant_wr;
    logic timeout_hit;

    assign wr_req = aw_full & w_full;
    assign rd_req = ar_full;
    // Write wins when it is alone, or when both wait and the read went last.
    assign grant_wr    = wr_req & (~rd_req | ~last_grant_wr);
    assign timeout_hit = HAS_TIMEOUT && (tcnt == TLAST);

    // Channel readiness comes straight from the flag registers, so a held
    // request blocks its channel until the matching response handshake.
    assign axi.awready = ~aw_full;
    assign axi.wready  = ~w_full;
    assign axi.arready = ~ar_full;
    assign axi.bvalid  = bvalid_q;
    assign axi.bresp   = bresp_q;
    assign axi.rvalid  = rvalid_q;
    assign axi.rresp   = rresp_q;
    assign axi.rdata   = rdata_q;

    assign addr_mem  = (state == S_WACC) ? aw_addr_q : ar_addr_q;
    assign wdata_mem = w_data_q;
    assign wmask_mem = w_strb_q;

    // NOTE: state is written with non-blocking assignments so every register
    // samples the pre-edge values; blocking here would chain updates in-cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: payload holding registers are reset too, so the mem-side
            // outputs derived from them are defined (zero) straight after reset.
            state         <= S_IDLE;
            aw_full       <= 1'b0;
            w_full        <= 1'b0;
            ar_full       <= 1'b0;
            aw_addr_q     <= '0;
            ar_addr_q     <= '0;
            w_data_q      <= '0;
            w_strb_q      <= '0;
            last_grant_wr <= 1'b0;
            tcnt          <= '0;
            wen_mem       <= 1'b0;
            ren_mem       <= 1'b0;
            bvalid_q      <= 1'b0;
            bresp_q       <= RESP_OKAY;
            rvalid_q      <= 1'b0;
            rresp_q       <= RESP_OKAY;
            rdata_q       <= '0;
        end else begin
            // Independent capture of each request channel.
            if (axi.awvalid && !aw_full) begin
                aw_full   <= 1'b1;
                aw_addr_q <= axi.awaddr;
            end
            if (axi.wvalid && !w_full) begin
                w_full   <= 1'b1;
                w_data_q <= axi.wdata;
                w_strb_q <= axi.wstrb;
            end
            if (axi.arvalid && !ar_full) begin
                ar_full   <= 1'b1;
                ar_addr_q <= axi.araddr;
            end

            case (state)
                S_IDLE: begin
                    if (grant_wr) begin
                        state   <= S_WACC;
                        wen_mem <= 1'b1;
                        tcnt    <= '0;
                        if (rd_req) last_grant_wr <= 1'b1;
                    end else if (rd_req) begin
                        state   <= S_RACC;
                        ren_mem <= 1'b1;
                        tcnt    <= '0;
                        if (wr_req) last_grant_wr <= 1'b0;
                    end
                end

                S_WACC: begin
                    // valid_mem is checked first so it beats a same-cycle timeout.
                    if (valid_mem || timeout_hit) begin
                        state    <= S_BRESP;
                        wen_mem  <= 1'b0;
                        bvalid_q <= 1'b1;
                        bresp_q  <= valid_mem ? RESP_OKAY : RESP_SLVERR;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end

                S_RACC: begin
                    if (valid_mem || timeout_hit) begin
                        state    <= S_RRESP;
                        ren_mem  <= 1'b0;
                        rvalid_q <= 1'b1;
                        rresp_q  <= valid_mem ? RESP_OKAY : RESP_SLVERR;
                        rdata_q  <= valid_mem ? rdata_mem : '0;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end

                S_BRESP: begin
                    if (axi.bready) begin
                        state    <= S_IDLE;
                        bvalid_q <= 1'b0;
                        aw_full  <= 1'b0;
                        w_full   <= 1'b0;
                    end
                end

                S_RRESP: begin
                    if (axi.rready) begin
                        state    <= S_IDLE;
                        rvalid_q <= 1'b0;
                        ar_full  <= 1'b0;
                    end
                end

                default: begin
                    state   <= S_IDLE;
                    wen_mem <= 1'b0;
                    ren_mem <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_axi_lite_arb.sv
// ---------------------------------------------------------------------------
// tb_mem_axi_lite_arb
// Directed bench for mem_axi_lite_arb (TIMEOUT=4). Stimulus is one linear
// sequence; every check compares a DUT output against a hand-computed value.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_mem_axi_lite_arb;

    localparam int DW = 64;
    localparam int AW = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic [AW-1:0]   addr_mem;
    logic [DW-1:0]   wdata_mem;
    logic [DW/8-1:0] wmask_mem;
    logic [DW-1:0]   rdata_mem;
    logic            valid_mem;
    logic            wen_mem;
    logic            ren_mem;

    int n_tests = 0;
    int n_fail  = 0;

    mem_axi_lite_arb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    mem_axi_lite_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .axi       (bus),
        .addr_mem  (addr_mem),
        .wdata_mem (wdata_mem),
        .wmask_mem (wmask_mem),
        .rdata_mem (rdata_mem),
        .valid_mem (valid_mem),
        .wen_mem   (wen_mem),
        .ren_mem   (ren_mem)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst         = 1'b1;
        bus.awaddr  = '0;
        bus.awvalid = 1'b0;
        bus.wdata   = '0;
        bus.wstrb   = '0;
        bus.wvalid  = 1'b0;
        bus.bready  = 1'b0;
        bus.araddr  = '0;
        bus.arvalid = 1'b0;
        bus.rready  = 1'b0;
        rdata_mem   = '0;
        valid_mem   = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_awready", 64'(bus.awready), 64'd1);
        check("rst_wready",  64'(bus.wready),  64'd1);
        check("rst_arready", 64'(bus.arready), 64'd1);
        check("rst_bvalid",  64'(bus.bvalid),  64'd0);
        check("rst_rvalid",  64'(bus.rvalid),  64'd0);
        check("rst_wen",     64'(wen_mem),     64'd0);
        check("rst_ren",     64'(ren_mem),     64'd0);
        check("rst_addr",    addr_mem,         64'd0);
        check("rst_rdata",   bus.rdata,        64'd0);
        rst = 1'b0;
        tick();

        // 1: AW+W together, valid_mem in the first access cycle
        bus.awaddr  = 64'h100;
        bus.awvalid = 1'b1;
        bus.wdata   = 64'hDEAD_BEEF;
        bus.wstrb   = 8'hFF;
        bus.wvalid  = 1'b1;
        tick();                                    // edge 0: handshake
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        valid_mem   = 1'b1;
        check("t1_awready_held", 64'(bus.awready), 64'd0);
        check("t1_wready_held",  64'(bus.wready),  64'd0);
        check("t1_wen_e0",       64'(wen_mem),     64'd0);
        tick();                                    // edge 1
        check("t1_wen_e1",   64'(wen_mem),     64'd1);
        check("t1_addr",     addr_mem,         64'h100);
        check("t1_wdata",    wdata_mem,        64'hDEAD_BEEF);
        check("t1_wmask",    64'(wmask_mem),   64'hFF);
        check("t1_bvalid_e1", 64'(bus.bvalid), 64'd0);
        tick();                                    // edge 2
        valid_mem = 1'b0;
        check("t1_wen_e2",    64'(wen_mem),    64'd0);
        check("t1_bvalid_e2", 64'(bus.bvalid), 64'd1);
        check("t1_bresp",     64'(bus.bresp),  64'd0);
        tick();                                    // bready low: response held
        check("t1_bvalid_hold", 64'(bus.bvalid), 64'd1);
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
        check("t1_bvalid_done", 64'(bus.bvalid), 64'd0);
        check("t1_awready_free", 64'(bus.awready), 64'd1);
        check("t1_wready_free",  64'(bus.wready),  64'd1);

        // 2: W four cycles ahead of AW
        bus.wdata  = 64'h1122_3344_5566_7788;
        bus.wstrb  = 8'h0F;
        bus.wvalid = 1'b1;
        tick();
        bus.wvalid = 1'b0;
        valid_mem  = 1'b1;
        check("t2_wready_drop", 64'(bus.wready), 64'd0);
        tick();
        tick();
        tick();
        check("t2_no_wen",      64'(wen_mem),     64'd0);
        check("t2_awready",     64'(bus.awready), 64'd1);
        bus.awaddr  = 64'h208;
        bus.awvalid = 1'b1;
        tick();                                    // AW handshake
        bus.awvalid = 1'b0;
        check("t2_wen_idle", 64'(wen_mem), 64'd0);
        tick();
        check("t2_wen",   64'(wen_mem),   64'd1);
        check("t2_addr",  addr_mem,       64'h208);
        check("t2_wdata", wdata_mem,      64'h1122_3344_5566_7788);
        check("t2_wmask", 64'(wmask_mem), 64'h0F);
        tick();
        valid_mem = 1'b0;
        check("t2_bvalid", 64'(bus.bvalid), 64'd1);
        check("t2_bresp",  64'(bus.bresp),  64'd0);
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;

        // 3: write and read contend right after reset -> write, then read
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.awaddr  = 64'h300;
        bus.awvalid = 1'b1;
        bus.wdata   = 64'hA5;
        bus.wvalid  = 1'b1;
        bus.araddr  = 64'h400;
        bus.arvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        bus.arvalid = 1'b0;
        tick();
        check("t3a_wen",  64'(wen_mem), 64'd1);
        check("t3a_ren",  64'(ren_mem), 64'd0);
        check("t3a_addr", addr_mem,     64'h300);
        valid_mem = 1'b1;
        tick();
        valid_mem  = 1'b0;
        bus.bready = 1'b1;
        check("t3a_bvalid", 64'(bus.bvalid), 64'd1);
        tick();
        bus.bready = 1'b0;
        tick();
        check("t3a_ren2",  64'(ren_mem), 64'd1);
        check("t3a_addr2", addr_mem,     64'h400);
        rdata_mem = 64'hCAFE;
        valid_mem = 1'b1;
        tick();
        valid_mem  = 1'b0;
        bus.rready = 1'b1;
        check("t3a_rvalid", 64'(bus.rvalid), 64'd1);
        check("t3a_rdata",  bus.rdata,       64'hCAFE);
        check("t3a_rresp",  64'(bus.rresp),  64'd0);
        tick();
        bus.rready = 1'b0;
        check("t3a_rvalid_done", 64'(bus.rvalid), 64'd0);

        // 3 repeat: contention again -> read goes first this time
        bus.awaddr  = 64'h310;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        bus.araddr  = 64'h410;
        bus.arvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        bus.arvalid = 1'b0;
        tick();
        check("t3b_ren",  64'(ren_mem), 64'd1);
        check("t3b_wen",  64'(wen_mem), 64'd0);
        check("t3b_addr", addr_mem,     64'h410);
        rdata_mem = 64'h1234;
        valid_mem = 1'b1;
        tick();
        valid_mem  = 1'b0;
        bus.rready = 1'b1;
        check("t3b_rdata", bus.rdata, 64'h1234);
        tick();
        bus.rready = 1'b0;
        tick();
        check("t3b_wen2",  64'(wen_mem), 64'd1);
        check("t3b_addr2", addr_mem,     64'h310);
        valid_mem = 1'b1;
        tick();
        valid_mem  = 1'b0;
        bus.bready = 1'b1;
        check("t3b_bvalid", 64'(bus.bvalid), 64'd1);
        tick();
        bus.bready = 1'b0;

        // 4: read timeout (TIMEOUT=4) with valid_mem stuck low
        rdata_mem   = 64'hFFFF;
        bus.araddr  = 64'h500;
        bus.arvalid = 1'b1;
        tick();
        bus.arvalid = 1'b0;
        tick();
        check("t4_ren_c1", 64'(ren_mem), 64'd1);
        tick();
        check("t4_ren_c2", 64'(ren_mem), 64'd1);
        tick();
        check("t4_ren_c3", 64'(ren_mem), 64'd1);
        tick();
        check("t4_ren_c4",    64'(ren_mem),    64'd1);
        check("t4_rvalid_c4", 64'(bus.rvalid), 64'd0);
        tick();
        check("t4_ren_off", 64'(ren_mem),    64'd0);
        check("t4_rvalid",  64'(bus.rvalid), 64'd1);
        check("t4_rresp",   64'(bus.rresp),  64'd2);
        check("t4_rdata",   bus.rdata,       64'd0);
        bus.rready = 1'b1;
        tick();
        bus.rready = 1'b0;

        // 5: valid_mem arrives in the cycle the timeout would fire
        bus.araddr  = 64'h600;
        bus.arvalid = 1'b1;
        tick();
        bus.arvalid = 1'b0;
        tick();
        tick();
        tick();
        tick();                                    // fourth access cycle
        check("t5_ren_last", 64'(ren_mem), 64'd1);
        rdata_mem = 64'h5A5A;
        valid_mem = 1'b1;
        tick();
        valid_mem = 1'b0;
        check("t5_rvalid", 64'(bus.rvalid), 64'd1);
        check("t5_rresp",  64'(bus.rresp),  64'd0);
        check("t5_rdata",  bus.rdata,       64'h5A5A);
        bus.rready = 1'b1;
        tick();
        bus.rready = 1'b0;

        // 6: reset while a write is in WACC and a read is held
        bus.awaddr  = 64'h700;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        bus.araddr  = 64'h800;
        bus.arvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        bus.arvalid = 1'b0;
        tick();
        check("t6_wen_before", 64'(wen_mem),     64'd1);
        check("t6_arready_before", 64'(bus.arready), 64'd0);
        rst = 1'b1;
        tick();
        check("t6_wen",     64'(wen_mem),     64'd0);
        check("t6_bvalid",  64'(bus.bvalid),  64'd0);
        check("t6_awready", 64'(bus.awready), 64'd1);
        check("t6_wready",  64'(bus.wready),  64'd1);
        check("t6_arready", 64'(bus.arready), 64'd1);
        rst = 1'b0;
        tick();
        tick();
        check("t6_wen_idle", 64'(wen_mem), 64'd0);
        check("t6_ren_idle", 64'(ren_mem), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
